uart_tx_fifo: RTL and testbench

Parametrised UART transmitter. Replaces the fixed 8-cycles-per-bit transmitter with:
- a runtime baud divisor;
- optional even/odd parity;
- one or two stop bits;
- a buffered valid/ready input FIFO.

Sits between the SoC bus/register block and the UART TXD pad. Sends LSB-first frames back-to-back while the FIFO holds data.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync_fifo.sv | 57 +++++
 rtl/uart_tx_fifo.sv | 132 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int unsigned UART_MIN_DIV = 2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level and a show-ahead read port.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [AW:0]      wr_ptr_nxt, rd_ptr_nxt;
    logic             do_wr, do_rd;

    always_comb begin
        do_wr      = wr_en && !full;
        do_rd      = rd_en && !empty;
        wr_ptr_nxt = wr_ptr + (AW+1)'(do_wr);
        rd_ptr_nxt = rd_ptr + (AW+1)'(do_rd);
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
            empty  <= (wr_ptr_nxt == rd_ptr_nxt);
            level  <= wr_ptr_nxt - rd_ptr_nxt;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: runtime divisor, optional parity, one or two stop bits.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned DIV_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [PAYLOAD_BITS-1:0]       tx_data,
    input  logic [DIV_W-1:0]              cfg_div,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_odd,
    input  logic                          cfg_two_stop,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned BCW = $clog2(PAYLOAD_BITS);

    uart_tx_state_t          state;
    logic [DIV_W-1:0]        div_cnt, div_lat, div_eff;
    logic [BCW-1:0]          bit_cnt;
    logic [PAYLOAD_BITS-1:0] shift, fifo_rdata;
    logic                    par_acc, par_en, two_stop;
    logic                    fifo_full, fifo_empty;
    logic                    bit_end, last_stop, frame_end, pop;

    uart_sync_fifo #(
        .WIDTH (PAYLOAD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tx_valid),
        .wr_data (tx_data),
        .rd_en   (pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        div_eff   = (cfg_div < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : cfg_div;
        bit_end   = (div_cnt == div_lat - DIV_W'(1));
        last_stop = !two_stop || (bit_cnt == BCW'(1));
        frame_end = (state == STOP) && bit_end && last_stop;
        pop       = !fifo_empty && ((state == IDLE) || frame_end);
    end

    assign tx_ready = !fifo_full;
    assign tx_busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            uart_txd <= 1'b1;
            tx_done  <= 1'b0;
            div_cnt  <= '0;
            div_lat  <= DIV_W'(UART_MIN_DIV);
            bit_cnt  <= '0;
            shift    <= '0;
            par_acc  <= 1'b0;
            par_en   <= 1'b0;
            two_stop <= 1'b0;
        end else begin
            div_cnt <= bit_end ? '0 : div_cnt + DIV_W'(1);
            // Registered pulse: set on the edge that enters the last stop cycle.
            tx_done <= (state == STOP) && last_stop && (div_cnt == div_lat - DIV_W'(2));
            if (pop) begin
                state    <= START;
                uart_txd <= 1'b0;
                div_cnt  <= '0;
                div_lat  <= div_eff;
                par_en   <= cfg_parity_en;
                two_stop <= cfg_two_stop;
                par_acc  <= cfg_parity_odd;
                shift    <= fifo_rdata;
                bit_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        div_cnt  <= '0;
                        uart_txd <= 1'b1;
                    end
                    START: if (bit_end) begin
                        state    <= DATA;
                        uart_txd <= shift[0];
                        par_acc  <= par_acc ^ shift[0];
                        shift    <= shift >> 1;
                        bit_cnt  <= '0;
                    end
                    DATA: if (bit_end) begin
                        if (bit_cnt == BCW'(PAYLOAD_BITS - 1)) begin
                            bit_cnt  <= '0;
                            state    <= par_en ? PARITY : STOP;
                            uart_txd <= par_en ? par_acc : 1'b1;
                        end else begin
                            uart_txd <= shift[0];
                            par_acc  <= par_acc ^ shift[0];
                            shift    <= shift >> 1;
                            bit_cnt  <= bit_cnt + BCW'(1);
                        end
                    end
                    PARITY: if (bit_end) begin
                        state    <= STOP;
                        uart_txd <= 1'b1;
                        bit_cnt  <= '0;
                    end
                    STOP: if (bit_end) begin
                        if (last_stop) begin
                            state <= IDLE;
                        end else begin
                            bit_cnt <= BCW'(1);
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        uart_txd <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame shapes, parity, stop bits, burst and reset abort.
module tb_uart_tx_fifo;

    logic        clk;
    logic        rst_n;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic [15:0] cfg_div;
    logic        cfg_parity_en;
    logic        cfg_parity_odd;
    logic        cfg_two_stop;
    logic        uart_txd;
    logic        tx_busy;
    logic        tx_done;
    logic [3:0]  fifo_level;

    int checks   = 0;
    int failures = 0;
    int dones    = 0;

    uart_tx_fifo #(
        .PAYLOAD_BITS (8),
        .FIFO_DEPTH   (8),
        .DIV_W        (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_data        (tx_data),
        .cfg_div        (cfg_div),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_two_stop   (cfg_two_stop),
        .uart_txd       (uart_txd),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done),
        .fifo_level     (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge showing cycle 'skip' of the frame; leaves one cycle past its end.
    task automatic expect_frame(input logic [7:0] d, input int div, input bit pen,
                                input bit podd, input bit two, input int skip);
        int nbits;
        int len;
        int b;
        logic e;
        nbits = 1 + 8 + (pen ? 1 : 0) + (two ? 2 : 1);
        len   = div * nbits;
        for (int c = skip; c < len; c++) begin
            b = c / div;
            if (b == 0)             e = 1'b0;
            else if (b <= 8)        e = d[b-1];
            else if (b == 9 && pen) e = (^d) ^ podd;
            else                    e = 1'b1;
            check($sformatf("txd d=%0h c=%0d", d, c), uart_txd, e);
            check($sformatf("done d=%0h c=%0d", d, c), tx_done, (c == len - 1));
            check($sformatf("busy d=%0h c=%0d", d, c), tx_busy, 1'b1);
            if (tx_done) dones++;
            @(negedge clk);
        end
    endtask

    // Push edge falls between the two negedges; returns at the negedge showing frame cycle 0.
    task automatic push_one(input logic [7:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
        check("level after push", fifo_level, 1);
        check("txd idle before pop", uart_txd, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] words [9];
        int         saw_done;
        int         saw_low;
        words = '{8'h11, 8'h22, 8'h3C, 8'h80, 8'h01, 8'hFF, 8'h00, 8'h96, 8'h5A};

        rst_n          = 1'b0;
        tx_valid       = 1'b0;
        tx_data        = 8'h00;
        cfg_div        = 16'd4;
        cfg_parity_en  = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_two_stop   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst txd", uart_txd, 1'b1);
        check("rst busy", tx_busy, 1'b0);
        check("rst done", tx_done, 1'b0);
        check("rst level", fifo_level, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst ready", tx_ready, 1'b1);
        check("post-rst level", fifo_level, 0);

        // Basic frame, 0xA5 -> 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit.
        push_one(8'hA5);
        check("frame start level", fifo_level, 0);
        expect_frame(8'hA5, 4, 1'b0, 1'b0, 1'b0, 0);
        check("busy falls after frame", tx_busy, 1'b0);
        check("txd idle after frame", uart_txd, 1'b1);

        // Parity frames, 44 cycles each.
        cfg_parity_en = 1'b1;
        push_one(8'hA5);
        expect_frame(8'hA5, 4, 1'b1, 1'b0, 1'b0, 0);
        cfg_parity_odd = 1'b1;
        push_one(8'hA5);
        expect_frame(8'hA5, 4, 1'b1, 1'b1, 1'b0, 0);
        cfg_parity_odd = 1'b0;
        push_one(8'h01);
        expect_frame(8'h01, 4, 1'b1, 1'b0, 1'b0, 0);
        cfg_parity_en = 1'b0;

        // Two stop bits, then clamped divisors.
        cfg_div      = 16'd3;
        cfg_two_stop = 1'b1;
        push_one(8'h3C);
        expect_frame(8'h3C, 3, 1'b0, 1'b0, 1'b1, 0);
        cfg_two_stop = 1'b0;
        cfg_div      = 16'd0;
        push_one(8'h81);
        expect_frame(8'h81, 2, 1'b0, 1'b0, 1'b0, 0);
        cfg_div = 16'd1;
        push_one(8'h5A);
        expect_frame(8'h5A, 2, 1'b0, 1'b0, 1'b0, 0);
        check("idle after clamp", tx_busy, 1'b0);

        // Divisor change mid-frame; second word pushed on the pop edge.
        cfg_div  = 16'd4;
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        @(negedge clk);
        tx_data = 8'h2D;
        check("level before push+pop", fifo_level, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        cfg_div  = 16'd8;
        check("level after push+pop", fifo_level, 1);
        expect_frame(8'hC3, 4, 1'b0, 1'b0, 1'b0, 0);
        expect_frame(8'h2D, 8, 1'b0, 1'b0, 1'b0, 0);
        check("idle after div change", tx_busy, 1'b0);

        // Burst of nine words at div 2; the FIFO fills to 8 and a tenth is refused.
        cfg_div = 16'd2;
        dones   = 0;
        for (int k = 0; k < 9; k++) begin
            tx_valid = 1'b1;
            tx_data  = words[k];
            if (k > 0) begin
                check($sformatf("burst level k=%0d", k), fifo_level, (k == 1) ? 1 : k - 1);
                check($sformatf("burst ready k=%0d", k), tx_ready, 1'b1);
            end
            @(negedge clk);
        end
        tx_data = 8'hEE;
        check("burst full level", fifo_level, 8);
        check("burst ready low", tx_ready, 1'b0);
        @(negedge clk);
        tx_valid = 1'b0;
        check("no push when full", fifo_level, 8);
        expect_frame(words[0], 2, 1'b0, 1'b0, 1'b0, 8);
        for (int k = 1; k < 9; k++) begin
            expect_frame(words[k], 2, 1'b0, 1'b0, 1'b0, 0);
        end
        check("burst done count", dones, 9);
        check("burst drained level", fifo_level, 0);
        check("burst idle", tx_busy, 1'b0);

        // Reset in the middle of DATA aborts the frame and flushes the FIFO.
        cfg_div = 16'd4;
        push_one(8'h00);
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("pre-abort txd", uart_txd, 1'b0);
        check("pre-abort busy", tx_busy, 1'b1);
        check("pre-abort level", fifo_level, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort txd", uart_txd, 1'b1);
        check("abort busy", tx_busy, 1'b0);
        check("abort level", fifo_level, 0);
        check("abort done", tx_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-abort txd", uart_txd, 1'b1);
        check("post-abort busy", tx_busy, 1'b0);
        check("post-abort level", fifo_level, 0);
        check("post-abort ready", tx_ready, 1'b1);
        saw_done = 0;
        saw_low  = 0;
        for (int i = 0; i < 60; i++) begin
            if (tx_done) saw_done++;
            if (!uart_txd) saw_low++;
            @(negedge clk);
        end
        check("no done after abort", saw_done, 0);
        check("line idle after abort", saw_low, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
